fabric_reset_sequencer: RTL and testbench

FABRIC_RESET_SEQUENCER -- requirements
Module: fabric_reset_sequencer

---
 rtl/fabric_reset_sequencer.sv | 178 +++++++++++++++++
 tb/tb_fabric_reset_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fabric_reset_sequencer.sv
// -----------------------------------------------------------------------------
// fabric_reset_sequencer
//
// Purpose:
//   Holds user fabric logic in reset until power is good, every required
//   initialization-done input is high and the fabric PLL is locked.  It then
//   counts HOLD_CYCLES with lock still high before it releases
//   fabric_reset_n.  The sequence restarts on loss of power, lock or done.
//   A sticky fault is raised if a wait state lasts too long.
//
// Ports:
//   clk               single clock for all logic
//   rst               synchronous, active-high reset
//   fabric_por_n      async power-on-reset status, 1 = power good
//   device_init_done  async device initialization complete
//   sram_init_done    async LSRAM initialization complete
//   usram_init_done   async uSRAM initialization complete
//   xcvr_init_done    async transceiver initialization complete
//   pll_lock          async fabric PLL lock
//   fabric_reset_n    registered active-low reset to user logic
//   ready             registered, high while the sequencer is in RUN
//   init_timeout      registered, sticky timeout fault flag
//   state             current FSM state code
//
// Configuration:
//   FABRIC_RESET_SEQ_XCVR_WAIT_EN  when defined, xcvr_init_done joins the
//   required done set.  Otherwise it is ignored and has no synchronizer.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module fabric_reset_sequencer #(
    parameter int unsigned HOLD_CYCLES    = 16,     // 1..65535
    parameter int unsigned TIMEOUT_CYCLES = 65535,  // 2..65535
    parameter int unsigned SYNC_STAGES    = 2       // 2..4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fabric_por_n,
    input  logic       device_init_done,
    input  logic       sram_init_done,
    input  logic       usram_init_done,
    input  logic       xcvr_init_done,
    input  logic       pll_lock,
    output logic       fabric_reset_n,
    output logic       ready,
    output logic       init_timeout,
    output logic [2:0] state
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_INIT = 3'd1;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd2;
    localparam logic [2:0] ST_HOLD      = 3'd3;
    localparam logic [2:0] ST_RUN       = 3'd4;
    localparam logic [2:0] ST_FAULT     = 3'd5;

    // Bit positions of each asynchronous input inside the synchronizer bank.
    localparam int BIT_POR   = 0;
    localparam int BIT_DEV   = 1;
    localparam int BIT_USRAM = 3;
    localparam int BIT_LOCK  = 4;

    // The wait counter sits at TIMEOUT_CYCLES-2 in the last permitted wait
    // cycle.  The next increment would reach TIMEOUT_CYCLES-1, so the FSM
    // enters FAULT instead.
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 2);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

`ifdef FABRIC_RESET_SEQ_XCVR_WAIT_EN
    localparam int NUM_IN   = 6;
    localparam int BIT_XCVR = 5;
`else
    localparam int NUM_IN   = 5;
`endif

    logic [NUM_IN-1:0]                   async_in;
    logic [SYNC_STAGES-1:0][NUM_IN-1:0]  sync_q;
    logic [NUM_IN-1:0]                   synced;
    logic                                por_ok;
    logic                                lock_ok;
    logic                                done_all;
    logic                                tmo_hit;
    logic                                hold_done;
    logic [15:0]                         tmo_cnt;
    logic [15:0]                         hold_cnt;
    logic [2:0]                          state_next;

`ifdef FABRIC_RESET_SEQ_XCVR_WAIT_EN
    assign async_in = {xcvr_init_done, pll_lock, usram_init_done,
                       sram_init_done, device_init_done, fabric_por_n};
`else
    logic unused_xcvr;
    assign unused_xcvr = xcvr_init_done;
    assign async_in    = {pll_lock, usram_init_done, sram_init_done,
                          device_init_done, fabric_por_n};
`endif

    // One independent SYNC_STAGES-deep shift chain per input bit.  Stage 0
    // samples the pins, and the FSM only looks at the last stage.
    // NOTE: synchronizer flops are cleared by rst.  This keeps a stale
    // "all done" from being seen in the first cycles after a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
        end
    end

    assign synced  = sync_q[SYNC_STAGES-1];
    assign por_ok  = synced[BIT_POR];
    assign lock_ok = synced[BIT_LOCK];

`ifdef FABRIC_RESET_SEQ_XCVR_WAIT_EN
    assign done_all = (&synced[BIT_USRAM:BIT_DEV]) & synced[BIT_XCVR];
`else
    assign done_all = &synced[BIT_USRAM:BIT_DEV];
`endif

    assign tmo_hit   = (tmo_cnt == TMO_LAST);
    assign hold_done = (hold_cnt == HOLD_LAST);

    // NOTE: state_next gets a default before the case statement, so every
    // path assigns it and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      if (por_ok) state_next = ST_WAIT_INIT;
            // An exit condition beats the timeout in the same cycle.
            ST_WAIT_INIT: if (done_all)     state_next = ST_WAIT_LOCK;
                          else if (tmo_hit) state_next = ST_FAULT;
            ST_WAIT_LOCK: if (lock_ok)      state_next = ST_HOLD;
                          else if (tmo_hit) state_next = ST_FAULT;
            ST_HOLD:      if (!lock_ok)       state_next = ST_WAIT_LOCK;
                          else if (hold_done) state_next = ST_RUN;
            // Losing a done input is the deeper failure, so it outranks
            // losing lock.
            ST_RUN:       if (!done_all)     state_next = ST_WAIT_INIT;
                          else if (!lock_ok) state_next = ST_WAIT_LOCK;
            ST_FAULT:     state_next = ST_FAULT;
            default:      state_next = ST_IDLE;
        endcase
        // Loss of power overrides every other transition in the active states.
        if (!por_ok && (state inside {ST_WAIT_INIT, ST_WAIT_LOCK, ST_HOLD, ST_RUN}))
            state_next = ST_IDLE;
    end

    // NOTE: all sequential state uses non-blocking assignments.  This way
    // every flop samples values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            tmo_cnt        <= '0;
            hold_cnt       <= '0;
            fabric_reset_n <= 1'b0;
            ready          <= 1'b0;
            init_timeout   <= 1'b0;
        end else begin
            state <= state_next;
            // Both counters restart on every state change.  They only run
            // in the states that use them.
            if (state_next != state) begin
                tmo_cnt  <= '0;
                hold_cnt <= '0;
            end else begin
                if (state == ST_WAIT_INIT || state == ST_WAIT_LOCK)
                    tmo_cnt <= tmo_cnt + 16'd1;
                if (state == ST_HOLD)
                    hold_cnt <= hold_cnt + 16'd1;
            end
            // The outputs follow the state register one cycle late.
            fabric_reset_n <= (state == ST_RUN);
            ready          <= (state == ST_RUN);
            init_timeout   <= init_timeout | (state == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_fabric_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fabric_reset_sequencer
//
// Self-checking bench for fabric_reset_sequencer.  A behavioural model
// derives the expected outputs for every cycle from the sequencing rules.
// Synchronizer delay is taken from a sample history queue, and one "cycles
// in current state" count covers both hold and timeout.  Directed scenarios
// are followed by a randomized soak.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_fabric_reset_sequencer;

    localparam int HOLD = 4;
    localparam int TMO  = 32;
    localparam int SYNC = 2;

    localparam int S_IDLE  = 0;
    localparam int S_WI    = 1;
    localparam int S_WL    = 2;
    localparam int S_HOLD  = 3;
    localparam int S_RUN   = 4;
    localparam int S_FAULT = 5;

`ifdef FABRIC_RESET_SEQ_XCVR_WAIT_EN
    localparam bit XCVR_REQ = 1'b1;
`else
    localparam bit XCVR_REQ = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       por_n, dev, sram, usram, xcvr, lock;
    logic       fabric_reset_n, ready, init_timeout;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state.
    int        m_state   = S_IDLE;
    int        m_dwell   = 0;
    bit        m_rstn    = 1'b0;
    bit        m_timeout = 1'b0;
    bit [5:0]  hist[$];

    fabric_reset_sequencer #(
        .HOLD_CYCLES   (HOLD),
        .TIMEOUT_CYCLES(TMO),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .fabric_por_n    (por_n),
        .device_init_done(dev),
        .sram_init_done  (sram),
        .usram_init_done (usram),
        .xcvr_init_done  (xcvr),
        .pll_lock        (lock),
        .fabric_reset_n  (fabric_reset_n),
        .ready           (ready),
        .init_timeout    (init_timeout),
        .state           (state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance the model by one clock edge.  The sampled inputs are the pin
    // values at this edge.
    task automatic model_step();
        bit [5:0] s;
        bit       por_ok, lock_ok, done_ok;
        int       nxt;
        if (rst) begin
            m_state   = S_IDLE;
            m_dwell   = 0;
            m_rstn    = 1'b0;
            m_timeout = 1'b0;
            hist.delete();
            return;
        end
        // The FSM sees the pin values from SYNC edges ago.  Before reset
        // history exists, it sees zeros.
        s       = (hist.size() >= SYNC) ? hist[hist.size() - SYNC] : 6'b0;
        por_ok  = s[0];
        lock_ok = s[4];
        done_ok = s[1] && s[2] && s[3] && (s[5] || !XCVR_REQ);

        m_rstn    = (m_state == S_RUN);
        m_timeout = m_timeout || (m_state == S_FAULT);

        nxt = m_state;
        if (m_state == S_IDLE)
            nxt = por_ok ? S_WI : S_IDLE;
        else if (m_state == S_FAULT)
            nxt = S_FAULT;
        else if (!por_ok)
            nxt = S_IDLE;
        else if (m_state == S_WI)
            nxt = done_ok ? S_WL : ((m_dwell + 1 >= TMO - 1) ? S_FAULT : S_WI);
        else if (m_state == S_WL)
            nxt = lock_ok ? S_HOLD : ((m_dwell + 1 >= TMO - 1) ? S_FAULT : S_WL);
        else if (m_state == S_HOLD)
            nxt = !lock_ok ? S_WL : ((m_dwell + 1 == HOLD) ? S_RUN : S_HOLD);
        else if (m_state == S_RUN)
            nxt = !done_ok ? S_WI : (!lock_ok ? S_WL : S_RUN);

        m_dwell = (nxt == m_state) ? m_dwell + 1 : 0;
        m_state = nxt;

        hist.push_back({xcvr, lock, usram, sram, dev, por_n});
        if (hist.size() > 8) void'(hist.pop_front());
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        check("state",          {29'd0, state},  m_state);
        check("fabric_reset_n", fabric_reset_n,  m_rstn);
        check("ready",          ready,           m_rstn);
        check("init_timeout",   init_timeout,    m_timeout);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_state(input int target, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (state === 3'(target)) break;
            tick();
        end
        check(tag, {29'd0, state}, target);
    endtask

    task automatic all_inputs(input logic v);
        por_n = v; dev = v; sram = v; usram = v; xcvr = v; lock = v;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int  dly[4];
        int  c0, n;
        bit  saw_low;
        int  sel;

        rst = 1'b1;
        all_inputs(1'b0);
        run(3);
        rst = 1'b0;
        check("reset_state",   {29'd0, state}, S_IDLE);
        check("reset_rstn",    fabric_reset_n, 0);
        check("reset_ready",   ready, 0);
        check("reset_timeout", init_timeout, 0);

        // Bring-up: power first, done inputs in random order, lock last.
        por_n = 1'b1;
        for (int i = 0; i < 4; i++) dly[i] = int'($urandom_range(9));
        for (int t = 0; t < 10; t++) begin
            if (t == dly[0]) dev   = 1'b1;
            if (t == dly[1]) sram  = 1'b1;
            if (t == dly[2]) usram = 1'b1;
            if (t == dly[3]) xcvr  = 1'b1;
            tick();
        end
        wait_state(S_WL, 20, "reach_wait_lock");
        lock = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 50; i++) begin
            if (fabric_reset_n === 1'b1) break;
            tick();
        end
        check("lock_to_reset_latency", cyc - c0, SYNC + HOLD + 2);
        check("run_state", {29'd0, state}, S_RUN);
        check("run_ready", ready, 1);
        run(5);

        // A three-cycle lock glitch in RUN falls back through WAIT_LOCK/HOLD.
        lock = 1'b0;
        run(3);
        lock = 1'b1;
        c0 = cyc;
        saw_low = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (fabric_reset_n === 1'b0) saw_low = 1'b1;
            if (saw_low && fabric_reset_n === 1'b1) break;
        end
        check("glitch_reset_dropped", saw_low, 1);
        check("glitch_recovery_latency", cyc - c0, SYNC + HOLD + 2);
        run(3);

        // A required done input drops briefly in RUN.
        sel = int'($urandom_range(2));
        case (sel)
            0:       dev   = 1'b0;
            1:       sram  = 1'b0;
            default: usram = 1'b0;
        endcase
        run(2);
        dev = 1'b1; sram = 1'b1; usram = 1'b1;
        run(25);
        check("done_drop_recovered", ready, 1);

        // Power and lock both drop while in HOLD: power wins, goes to IDLE.
        lock = 1'b0;
        run(3);
        lock = 1'b1;
        wait_state(S_HOLD, 20, "reach_hold");
        por_n = 1'b0;
        lock  = 1'b0;
        run(3);
        check("hold_abort_idle", {29'd0, state}, S_IDLE);
        run(3);
        por_n = 1'b1;
        lock  = 1'b1;
        wait_state(S_RUN, 40, "rebringup_run");
        run(2);

        // One-cycle reset in RUN aborts at once; the sequence then repeats.
        pulse_reset();
        check("rst_pulse_state", {29'd0, state}, S_IDLE);
        check("rst_pulse_rstn",  fabric_reset_n, 0);
        check("rst_pulse_ready", ready, 0);
        wait_state(S_RUN, 40, "run_after_rst");
        run(2);
        check("rstn_after_rst", fabric_reset_n, 1);

        // Timeout in WAIT_INIT with sram_init_done held low.
        sram = 1'b0;
        pulse_reset();
        n = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (state === 3'(S_WI)) n++;
            if (state === 3'(S_FAULT)) break;
        end
        check("wait_init_cycles", n, TMO - 1);
        run(2);
        check("timeout_flag", init_timeout, 1);
        sram = 1'b1;
        run(40);
        check("fault_sticky_state", {29'd0, state}, S_FAULT);
        check("fault_sticky_flag", init_timeout, 1);

        // Timeout in WAIT_LOCK.
        lock = 1'b0;
        pulse_reset();
        run(60);
        check("wait_lock_fault", {29'd0, state}, S_FAULT);

        // Transceiver done held low: blocks only when it is required.
        all_inputs(1'b1);
        xcvr = 1'b0;
        pulse_reset();
        run(20);
        check("xcvr_gate_state", {29'd0, state}, XCVR_REQ ? S_WI : S_RUN);
        xcvr = 1'b1;
        run(30);

        // Randomized soak: inputs usually high, brief random drops, rare resets.
        all_inputs(1'b1);
        pulse_reset();
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(399) == 0);
            if (por_n) por_n = !($urandom_range(119) == 0); else por_n = ($urandom_range(3) == 0);
            if (dev)   dev   = !($urandom_range(59)  == 0); else dev   = ($urandom_range(3) == 0);
            if (sram)  sram  = !($urandom_range(59)  == 0); else sram  = ($urandom_range(3) == 0);
            if (usram) usram = !($urandom_range(59)  == 0); else usram = ($urandom_range(3) == 0);
            if (xcvr)  xcvr  = !($urandom_range(59)  == 0); else xcvr  = ($urandom_range(3) == 0);
            if (lock)  lock  = !($urandom_range(39)  == 0); else lock  = ($urandom_range(3) == 0);
            tick();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
